// File: rtl/ram_seq_access_ctrl_if.sv
// rtl/ram_seq_access_ctrl_if.sv - RAM port and byte-stream bundle for the sequential RAM initiator
interface ram_seq_access_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output mem_we, mem_addr, mem_din, m_data, m_valid, m_last,
        input  mem_dout, m_ready
    );

    modport slave (
        input  mem_we, mem_addr, mem_din, m_data, m_valid, m_last,
        output mem_dout, m_ready
    );
endinterface

// File: rtl/ram_seq_access_ctrl.sv
// rtl/ram_seq_access_ctrl.sv - fills or dumps a 2**ADDR_W x DATA_W RAM; RAM_DUMP_CSUM_EN appends an XOR checksum beat to dumps
module ram_seq_access_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    ram_seq_access_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] K_LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [DATA_W-1:0] csum_q, csum_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            base_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            csum_q    <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base_q    <= base_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            csum_q    <= csum_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        base_d    = base_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        csum_d    = csum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = fill_val;
                    k_d     = '0;
                    csum_d  = '0;
                    state_d = mode ? S_FILL : S_READ;
                end
            end
            S_FILL: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_READ: begin
                m_data_d  = bus.mem_dout;
                m_valid_d = 1'b1;
                csum_d    = csum_q ^ bus.mem_dout;
`ifdef RAM_DUMP_CSUM_EN
                m_last_d  = 1'b0;
`else
                m_last_d  = (k_q == K_LAST);
`endif
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (bus.m_ready) begin
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        state_d   = S_DONE;
`ifdef RAM_DUMP_CSUM_EN
                    // Final data beat accepted: stay in SEND and present the checksum.
                    end else if (k_q == K_LAST) begin
                        m_data_d = csum_q;
                        m_last_d = 1'b1;
`endif
                    end else begin
                        k_d       = k_q + 1'b1;
                        m_valid_d = 1'b0;
                        state_d   = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        bus.mem_we   = (state_q == S_FILL);
        bus.mem_addr = (state_q == S_FILL || state_q == S_READ || state_q == S_SEND) ? k_q : '0;
        bus.mem_din  = (state_q == S_FILL) ? base_q + DATA_W'(k_q) : '0;
        bus.m_data   = m_data_q;
        bus.m_valid  = m_valid_q;
        bus.m_last   = m_last_q;
    end
endmodule

// File: tb/tb_ram_seq_access_ctrl.sv
// tb/tb_ram_seq_access_ctrl.sv - scoreboard bench for ram_seq_access_ctrl with a behavioural 16x8 RAM
module tb_ram_seq_access_ctrl;
`ifdef RAM_DUMP_CSUM_EN
    localparam int NBEATS    = 17;
    localparam int DUMP_DONE = 34;
`else
    localparam int NBEATS    = 16;
    localparam int DUMP_DONE = 33;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] fill_val;
    logic       busy;
    logic       done;

    ram_seq_access_ctrl_if bus ();

    ram_seq_access_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    logic       tb_we;
    logic [3:0] tb_waddr;
    logic [7:0] tb_wdata;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
    end
    assign bus.mem_dout = mem[bus.mem_addr];

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_beats [$];
    logic [11:0] exp_wr [$];
    logic [7:0]  exp_mem [16];
    int          beats_seen = 0;
    int          writes_seen = 0;
    int          done_seen = 0;
    logic [7:0]  last_beat_data = 8'h00;
    beat_t       eb;
    logic [11:0] ew;

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_seen++;
            if (bus.mem_we) begin
                writes_seen++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h", bus.mem_addr, bus.mem_din);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({bus.mem_addr, bus.mem_din} !== ew) begin
                        errors++;
                        $display("FAIL fill_write got addr=%0h data=%0h expected addr=%0h data=%0h",
                                 bus.mem_addr, bus.mem_din, ew[11:8], ew[7:0]);
                    end
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                beats_seen++;
                last_beat_data = bus.m_data;
                checks++;
                if (exp_beats.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat data=%0h last=%0b", bus.m_data, bus.m_last);
                end else begin
                    eb = exp_beats.pop_front();
                    if (bus.m_data !== eb.data || bus.m_last !== eb.last) begin
                        errors++;
                        $display("FAIL dump_beat got data=%0h last=%0b expected data=%0h last=%0b",
                                 bus.m_data, bus.m_last, eb.data, eb.last);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic m, input logic [7:0] v);
        start    = 1'b1;
        mode     = m;
        fill_val = v;
        tick();
        start = 1'b0;
    endtask

    task automatic run_fill(input logic [7:0] v);
        int c;
        int w0;
        w0 = writes_seen;
        for (int k = 0; k < 16; k++) begin
            exp_mem[k] = v + 8'(k);
            exp_wr.push_back({4'(k), 8'(v + 8'(k))});
        end
        do_start(1'b1, v);
        chk("fill_we_first_cycle", {31'd0, bus.mem_we}, 32'd1);
        c = 1;
        while (!done && c < 60) begin
            tick();
            c++;
        end
        chk("fill_done_cycle", c, 17);
        chk("fill_write_count", writes_seen - w0, 16);
        tick();
        chk("fill_idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic push_dump();
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < 16; k++) begin
            x ^= exp_mem[k];
`ifdef RAM_DUMP_CSUM_EN
            exp_beats.push_back({exp_mem[k], 1'b0});
`else
            exp_beats.push_back({exp_mem[k], (k == 15)});
`endif
        end
`ifdef RAM_DUMP_CSUM_EN
        exp_beats.push_back({x, 1'b1});
`endif
    endtask

    task automatic dump_free();
        int c;
        push_dump();
        bus.m_ready = 1'b1;
        do_start(1'b0, 8'h00);
        chk("dump_valid_cycle1", {31'd0, bus.m_valid}, 32'd0);
        tick();
        chk("dump_valid_cycle2", {31'd0, bus.m_valid}, 32'd1);
        c = 2;
        while (!done && c < 100) begin
            tick();
            c++;
        end
        chk("dump_done_cycle", c, DUMP_DONE);
        chk("dump_done_valid_low", {31'd0, bus.m_valid}, 32'd0);
        tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.m_valid && n < 10) begin
            tick();
            n++;
        end
        if (!bus.m_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid timeout got m_valid=0 expected 1");
        end
    endtask

    task automatic accept();
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("wait_done_seen", {31'd0, done}, 32'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        int d0, b0, w0, c;
        rst = 1'b1; start = 1'b0; mode = 1'b0; fill_val = 8'h00;
        bus.m_ready = 1'b0; tb_we = 1'b0; tb_waddr = 4'h0; tb_wdata = 8'h00;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_m_last", {31'd0, bus.m_last}, 32'd0);
        chk("rst_mem_addr", {28'd0, bus.mem_addr}, 32'd0);
        chk("rst_mem_din", {24'd0, bus.mem_din}, 32'd0);
        chk("rst_m_data", {24'd0, bus.m_data}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: fill with wrap
        run_fill(8'hF8);
        chk("fill_mem7", {24'd0, mem[7]}, 32'hFF);
        chk("fill_mem8", {24'd0, mem[8]}, 32'h00);
        chk("fill_mem15", {24'd0, mem[15]}, 32'h07);

        // 2: free-running dump
        dump_free();
`ifdef RAM_DUMP_CSUM_EN
        chk("dump_last_beat", {24'd0, last_beat_data}, 32'h00);
`else
        chk("dump_last_beat", {24'd0, last_beat_data}, 32'h07);
`endif

        // 3: backpressure on beat 4
        push_dump();
        do_start(1'b0, 8'h00);
        for (int b = 0; b < NBEATS; b++) begin
            wait_valid();
            if (b == 4) begin
                for (int h = 0; h < 5; h++) begin
                    chk("bp_valid_held", {31'd0, bus.m_valid}, 32'd1);
                    chk("bp_data_held", {24'd0, bus.m_data}, 32'hFC);
                    chk("bp_addr_held", {28'd0, bus.mem_addr}, 32'd4);
                    tick();
                end
            end
            accept();
        end
        wait_done();

        // 4: checksum over a patched fill
        run_fill(8'h00);
        tb_we = 1'b1; tb_waddr = 4'd3; tb_wdata = 8'h5A;
        tick();
        tb_we = 1'b0;
        exp_mem[3] = 8'h5A;
        dump_free();
`ifdef RAM_DUMP_CSUM_EN
        chk("csum_beat", {24'd0, last_beat_data}, 32'h59);
`else
        chk("csum_off_last_beat", {24'd0, last_beat_data}, 32'h0F);
`endif

        // 5: start held high while busy, including the done cycle
        d0 = done_seen; b0 = beats_seen; w0 = writes_seen;
        push_dump();
        bus.m_ready = 1'b1;
        do_start(1'b0, 8'h00);
        start = 1'b1; mode = 1'b1; fill_val = 8'h33;
        c = 1;
        while (!done && c < 100) begin
            tick();
            c++;
        end
        chk("busy_start_done_cycle", c, DUMP_DONE);
        tick();
        start = 1'b0;
        chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
        bus.m_ready = 1'b0;
        repeat (40) tick();
        chk("busy_start_done_count", done_seen - d0, 1);
        chk("busy_start_beat_count", beats_seen - b0, NBEATS);
        chk("busy_start_no_writes", writes_seen - w0, 0);

        // 6: reset while beat 7 is presented
        push_dump();
        do_start(1'b0, 8'h00);
        for (int b = 0; b < 7; b++) begin
            wait_valid();
            accept();
        end
        wait_valid();
        chk("rst_mid_beat7_data", {24'd0, bus.m_data}, {24'd0, exp_mem[7]});
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_mid_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mid_mem_addr", {28'd0, bus.mem_addr}, 32'd0);
        chk("rst_mid_m_last", {31'd0, bus.m_last}, 32'd0);
        rst = 1'b0;
        exp_beats.delete();
        tick();
        dump_free();

        chk("beats_queue_empty", exp_beats.size(), 0);
        chk("writes_queue_empty", exp_wr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
